// File: rtl/flash_arb_pkg.sv
// ---------------------------------------------------------------------------
// flash_arb_pkg
//
// Purpose: shared definitions for the management flash pass-thru arbiter.
//   Holds the FSM state encoding, the default timing constants, the width of
//   the deselect/restart down-counter and a small helper that turns a cycle
//   count into the value loaded into that counter.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package flash_arb_pkg;

  // Width of the shared deselect/restart down-counter; both intervals are
  // limited to 1..255 cycles so eight bits are enough.
  localparam int ARB_CNT_W = 8;

  // Default interval lengths and synchronizer depth.
  localparam int DEF_DESELECT_CYCLES = 4;
  localparam int DEF_RESTART_CYCLES  = 16;
  localparam int DEF_SYNC_STAGES     = 2;

  typedef logic [ARB_CNT_W-1:0] arb_cnt_t;

  // Ownership FSM states. Plain constants keep the encoding fixed so the
  // state register can be probed by older tooling that expects raw codes.
  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ST_CORE    = 3'd0;
  localparam arb_state_t ST_DRAIN   = 3'd1;
  localparam arb_state_t ST_PASS    = 3'd2;
  localparam arb_state_t ST_DESEL   = 3'd3;
  localparam arb_state_t ST_RESTART = 3'd4;

  // Snapshot of the four pins the arbiter drives toward the flash pads.
  typedef struct packed {
    logic csb;
    logic sck;
    logic io0_do;
    logic io0_oeb;
  } flash_pins_t;

  // Pins parked while nobody owns the flash: deselected, clock low, io0
  // tristated.
  localparam flash_pins_t PINS_IDLE = '{csb: 1'b1, sck: 1'b0, io0_do: 1'b0, io0_oeb: 1'b1};

  // The counter expires on the edge where it reads zero, so an interval of
  // N cycles is realised by loading N-1.
  function automatic arb_cnt_t cycles_to_load(input int cycles);
    return arb_cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/flash_arb_sync.sv
// ---------------------------------------------------------------------------
// flash_arb_sync
//
// Purpose: multi-flop synchronizer bringing the housekeeping pass-thru
//   request into the management clock domain. Flops clear to 0 on reset so
//   the arbiter always starts with the core owning the flash.
//
// Ports:
//   clk       in   management clock
//   resetn    in   asynchronous active-low reset
//   async_in  in   signal from another clock domain
//   sync_out  out  async_in delayed by STAGES clk edges, metastability-safe
// ---------------------------------------------------------------------------
module flash_arb_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] sync_q;

  // Shift chain: the input lands in bit 0 and walks toward the top bit.
  // Only the top bit is consumed, giving the earlier stages time to settle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/flash_passthru_arbiter.sv
// ---------------------------------------------------------------------------
// flash_passthru_arbiter
//
// Purpose: shares the single management flash SPI port between the CPU
//   flash controller and the housekeeping SPI pass-thru path. A pass-thru
//   request holds the CPU in reset, lets any in-flight core transfer finish,
//   then hands the pins to the external host. On release the flash is kept
//   deselected for DESELECT_CYCLES and the CPU stays held for a further
//   RESTART_CYCLES before the core regains the port. The pass-thru data
//   path is purely combinational; only ownership changes are clocked.
//
// Ports:
//   clk, resetn                 management clock, async active-low reset
//   core_csb/core_sck           chip select / clock from flash controller
//   core_io0_do/core_io0_oeb    controller MOSI and its output enable (low)
//   core_io1_di                 MISO returned to the controller (1 if not owner)
//   pt_req                      pass-thru active, asynchronous to clk
//   pt_csb/pt_sck/pt_sdi        housekeeping SPI pins
//   pt_sdo                      MISO back to housekeeping (0 if not owner)
//   flash_csb/flash_clk/flash_io0_do  to flash pads
//   flash_io0_oeb/flash_io1_oeb pad output enables, active low
//   flash_io1_di                MISO from the flash pad
//   cpu_hold                    keeps CPU and flash controller in reset
//   pt_grant                    high while pass-thru owns the pins
// ---------------------------------------------------------------------------
module flash_passthru_arbiter
  import flash_arb_pkg::*;
#(
  parameter int DESELECT_CYCLES = DEF_DESELECT_CYCLES,
  parameter int RESTART_CYCLES  = DEF_RESTART_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic resetn,
  input  logic core_csb,
  input  logic core_sck,
  input  logic core_io0_do,
  input  logic core_io0_oeb,
  output logic core_io1_di,
  input  logic pt_req,
  input  logic pt_csb,
  input  logic pt_sck,
  input  logic pt_sdi,
  output logic pt_sdo,
  output logic flash_csb,
  output logic flash_clk,
  output logic flash_io0_do,
  output logic flash_io0_oeb,
  output logic flash_io1_oeb,
  input  logic flash_io1_di,
  output logic cpu_hold,
  output logic pt_grant
);

  logic        req_s;
  arb_state_t  state_q;
  arb_state_t  state_d;
  arb_cnt_t    cnt_q;
  arb_cnt_t    cnt_d;
  flash_pins_t core_pins;
  flash_pins_t pt_pins;
  flash_pins_t pins_out;

  flash_arb_sync #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk      (clk),
    .resetn   (resetn),
    .async_in (pt_req),
    .sync_out (req_s)
  );

  // Next-state and counter logic. DRAIN waits for the controller to drop
  // chip select so a core transfer is never cut mid-frame. DESEL ignores a
  // new request on purpose: the flash must see its full deselect time
  // before anyone drives it again. RESTART, by contrast, may hand straight
  // back to pass-thru because the CPU is still held and the flash is idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CORE: begin
        if (req_s) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (core_csb) begin
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        if (!req_s) begin
          state_d = ST_DESEL;
          cnt_d   = cycles_to_load(DESELECT_CYCLES);
        end
      end
      ST_DESEL: begin
        if (cnt_q == '0) begin
          state_d = ST_RESTART;
          cnt_d   = cycles_to_load(RESTART_CYCLES);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESTART: begin
        if (req_s) begin
          state_d = ST_PASS;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_CORE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_CORE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers. Reset returns ownership to the core at
  // once, which aborts any pass-thru transfer that was in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_CORE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign core_pins = '{csb: core_csb, sck: core_sck, io0_do: core_io0_do, io0_oeb: core_io0_oeb};
  assign pt_pins   = '{csb: pt_csb, sck: pt_sck, io0_do: pt_sdi, io0_oeb: 1'b0};

  // Pin steering. The core keeps the pins through DRAIN so its last
  // transfer completes cleanly; pass-thru gets them only in PASS. In the
  // DESEL/RESTART gap the pins are parked and both MISO returns are held at
  // their inactive levels so neither master sees stray flash data.
  always_comb begin
    pins_out    = PINS_IDLE;
    core_io1_di = 1'b1;
    pt_sdo      = 1'b0;
    case (state_q)
      ST_CORE, ST_DRAIN: begin
        pins_out    = core_pins;
        core_io1_di = flash_io1_di;
      end
      ST_PASS: begin
        pins_out = pt_pins;
        pt_sdo   = flash_io1_di;
      end
      default: begin
        pins_out = PINS_IDLE;
      end
    endcase
  end

  assign flash_csb     = pins_out.csb;
  assign flash_clk     = pins_out.sck;
  assign flash_io0_do  = pins_out.io0_do;
  assign flash_io0_oeb = pins_out.io0_oeb;
  assign flash_io1_oeb = 1'b1;

  assign cpu_hold = (state_q != ST_CORE);
  assign pt_grant = (state_q == ST_PASS);

endmodule

// File: tb/tb_flash_passthru_arbiter.sv
// ---------------------------------------------------------------------------
// tb_flash_passthru_arbiter
//
// Purpose: directed self-checking bench for flash_passthru_arbiter with
//   default parameters (DESELECT 4, RESTART 16, SYNC 2). A small SPI flash
//   model hangs off the flash pins and answers a read command.
// ---------------------------------------------------------------------------
module tb_flash_passthru_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic core_csb = 1'b1;
  logic core_sck = 1'b0;
  logic core_io0_do = 1'b0;
  logic core_io0_oeb = 1'b1;
  logic core_io1_di;
  logic pt_req = 1'b0;
  logic pt_csb = 1'b1;
  logic pt_sck = 1'b0;
  logic pt_sdi = 1'b0;
  logic pt_sdo;
  logic flash_csb;
  logic flash_clk;
  logic flash_io0_do;
  logic flash_io0_oeb;
  logic flash_io1_oeb;
  logic flash_io1_di;
  logic cpu_hold;
  logic pt_grant;

  logic tb_miso = 1'b0;
  logic fm_en = 1'b0;
  logic fm_bit = 1'b0;

  int checks = 0;
  int failures = 0;

  flash_passthru_arbiter dut (
    .clk           (clk),
    .resetn        (resetn),
    .core_csb      (core_csb),
    .core_sck      (core_sck),
    .core_io0_do   (core_io0_do),
    .core_io0_oeb  (core_io0_oeb),
    .core_io1_di   (core_io1_di),
    .pt_req        (pt_req),
    .pt_csb        (pt_csb),
    .pt_sck        (pt_sck),
    .pt_sdi        (pt_sdi),
    .pt_sdo        (pt_sdo),
    .flash_csb     (flash_csb),
    .flash_clk     (flash_clk),
    .flash_io0_do  (flash_io0_do),
    .flash_io0_oeb (flash_io0_oeb),
    .flash_io1_oeb (flash_io1_oeb),
    .flash_io1_di  (flash_io1_di),
    .cpu_hold      (cpu_hold),
    .pt_grant      (pt_grant)
  );

  // 100 MHz management clock.
  always #5 clk = ~clk;

  // MISO seen by the arbiter comes from the flash model during the read
  // scenario, otherwise from a directly driven bench bit.
  assign flash_io1_di = fm_en ? fm_bit : tb_miso;

  logic [7:0]  fm_mem [0:15];
  int          fm_bits = 0;
  logic [31:0] fm_hdr = '0;

  initial begin
    for (int i = 0; i < 16; i++) fm_mem[i] = 8'ha5;
    fm_mem[0] = 8'h6f;
    fm_mem[1] = 8'h00;
    fm_mem[2] = 8'h00;
    fm_mem[3] = 8'h0b;
  end

  function automatic logic fm_data_bit(input int k, input logic [23:0] addr);
    int idx;
    logic [7:0] b;
    idx = (int'(addr) + k / 8) % 16;
    b = fm_mem[idx[3:0]];
    return b[7 - (k % 8)];
  endfunction

  // Mode-0 flash model: a frame starts on chip-select fall (clock low),
  // command and 24-bit address are shifted in on rising edges, data is
  // shifted out on falling edges.
  always @(posedge flash_clk or negedge flash_csb) begin
    if (!flash_clk) begin
      fm_bits <= 0;
    end else if (!flash_csb) begin
      if (fm_bits < 32) fm_hdr <= {fm_hdr[30:0], flash_io0_do};
      fm_bits <= fm_bits + 1;
    end
  end

  always @(negedge flash_clk) begin
    if (!flash_csb && fm_bits >= 32) fm_bit <= fm_data_bit(fm_bits - 32, fm_hdr[23:0]);
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pt_xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      pt_sdi = tx[i];
      #7;
      pt_sck = 1'b1;
      rx[i] = pt_sdo;
      #7;
      pt_sck = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("[TB] FAIL reset_cpu_hold: got %b expected 0", cpu_hold); end
    checks++; if (pt_grant !== 1'b0) begin failures++; $display("[TB] FAIL reset_pt_grant: got %b expected 0", pt_grant); end
    checks++; if ({flash_csb, flash_clk, flash_io0_oeb} !== 3'b101) begin failures++; $display("[TB] FAIL reset_pins: got %b expected 101", {flash_csb, flash_clk, flash_io0_oeb}); end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step(2);
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("[TB] FAIL reset_release_hold: got %b expected 0", cpu_hold); end
  endtask

  task automatic test_idle();
    // {core_csb, core_sck, core_io0_do, core_io0_oeb, miso}
    logic [4:0] vec [4];
    vec[0] = 5'b01101;
    vec[1] = 5'b00000;
    vec[2] = 5'b10111;
    vec[3] = 5'b01001;
    for (int i = 0; i < 4; i++) begin
      {core_csb, core_sck, core_io0_do, core_io0_oeb, tb_miso} = vec[i];
      #1;
      checks++; if ({flash_csb, flash_clk, flash_io0_do, flash_io0_oeb} !== vec[i][4:1]) begin failures++; $display("[TB] FAIL idle_pins[%0d]: got %b expected %b", i, {flash_csb, flash_clk, flash_io0_do, flash_io0_oeb}, vec[i][4:1]); end
      checks++; if (core_io1_di !== vec[i][0]) begin failures++; $display("[TB] FAIL idle_miso[%0d]: got %b expected %b", i, core_io1_di, vec[i][0]); end
      checks++; if ({flash_io1_oeb, pt_sdo, cpu_hold, pt_grant} !== 4'b1000) begin failures++; $display("[TB] FAIL idle_ctrl[%0d]: got %b expected 1000", i, {flash_io1_oeb, pt_sdo, cpu_hold, pt_grant}); end
      step(1);
    end
    tb_miso = 1'b0;
  endtask

  task automatic test_core_in_flight();
    core_csb = 1'b0;
    core_sck = 1'b1;
    pt_req = 1'b1;
    step(2);
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("[TB] FAIL drain_hold_early: got %b expected 0", cpu_hold); end
    step(1);
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("[TB] FAIL drain_hold_edge3: got %b expected 1", cpu_hold); end
    checks++; if ({pt_grant, flash_csb, flash_clk} !== 3'b001) begin failures++; $display("[TB] FAIL drain_core_pins: got %b expected 001", {pt_grant, flash_csb, flash_clk}); end
    step(2);
    checks++; if ({pt_grant, flash_csb} !== 2'b00) begin failures++; $display("[TB] FAIL drain_wait: got %b expected 00", {pt_grant, flash_csb}); end
    core_csb = 1'b1;
    core_sck = 1'b0;
    #1;
    checks++; if (pt_grant !== 1'b0) begin failures++; $display("[TB] FAIL drain_grant_before_edge: got %b expected 0", pt_grant); end
    step(1);
    checks++; if ({pt_grant, flash_io0_oeb} !== 2'b10) begin failures++; $display("[TB] FAIL pass_grant: got %b expected 10", {pt_grant, flash_io0_oeb}); end
    pt_csb = 1'b0;
    #1;
    checks++; if (flash_csb !== 1'b0) begin failures++; $display("[TB] FAIL pass_csb_follow: got %b expected 0", flash_csb); end
    pt_csb = 1'b1;
    #1;
  endtask

  task automatic test_pass_read();
    logic [7:0] rx;
    logic [7:0] exp_data [4];
    exp_data[0] = 8'h6f;
    exp_data[1] = 8'h00;
    exp_data[2] = 8'h00;
    exp_data[3] = 8'h0b;
    fm_en = 1'b1;
    pt_csb = 1'b0;
    #7;
    pt_xfer(8'h03, rx);
    pt_xfer(8'h00, rx);
    pt_xfer(8'h00, rx);
    pt_xfer(8'h00, rx);
    for (int i = 0; i < 4; i++) begin
      pt_xfer(8'h00, rx);
      checks++; if (rx !== exp_data[i]) begin failures++; $display("[TB] FAIL read_byte[%0d]: got %h expected %h", i, rx, exp_data[i]); end
      if (i == 1) begin
        checks++; if (core_io1_di !== 1'b1) begin failures++; $display("[TB] FAIL pass_core_miso: got %b expected 1", core_io1_di); end
      end
    end
    #7;
    pt_csb = 1'b1;
    #7;
    fm_en = 1'b0;
    step(1);
  endtask

  task automatic test_release();
    core_csb = 1'b0;
    core_sck = 1'b1;
    tb_miso = 1'b0;
    pt_req = 1'b0;
    step(2);
    checks++; if (pt_grant !== 1'b1) begin failures++; $display("[TB] FAIL release_grant_held: got %b expected 1", pt_grant); end
    step(1);
    checks++; if ({pt_grant, cpu_hold, flash_csb, flash_clk, flash_io0_oeb} !== 5'b01101) begin failures++; $display("[TB] FAIL desel_entry: got %b expected 01101", {pt_grant, cpu_hold, flash_csb, flash_clk, flash_io0_oeb}); end
    checks++; if ({core_io1_di, pt_sdo} !== 2'b10) begin failures++; $display("[TB] FAIL desel_miso: got %b expected 10", {core_io1_di, pt_sdo}); end
    for (int n = 1; n <= 20; n++) begin
      step(1);
      checks++; if (cpu_hold !== (n < 20)) begin failures++; $display("[TB] FAIL release_hold[%0d]: got %b expected %b", n, cpu_hold, (n < 20)); end
      if (n < 20) begin
        checks++; if (flash_csb !== 1'b1) begin failures++; $display("[TB] FAIL release_csb[%0d]: got %b expected 1", n, flash_csb); end
      end
    end
    checks++; if ({flash_csb, flash_clk, core_io1_di} !== 3'b010) begin failures++; $display("[TB] FAIL release_core_back: got %b expected 010", {flash_csb, flash_clk, core_io1_di}); end
  endtask

  task automatic test_restart_reassert();
    core_csb = 1'b1;
    core_sck = 1'b0;
    pt_req = 1'b1;
    step(3);
    checks++; if ({cpu_hold, pt_grant} !== 2'b10) begin failures++; $display("[TB] FAIL rs_drain: got %b expected 10", {cpu_hold, pt_grant}); end
    step(1);
    checks++; if (pt_grant !== 1'b1) begin failures++; $display("[TB] FAIL rs_pass: got %b expected 1", pt_grant); end
    pt_req = 1'b0;
    step(3);
    checks++; if (pt_grant !== 1'b0) begin failures++; $display("[TB] FAIL rs_desel: got %b expected 0", pt_grant); end
    for (int n = 1; n <= 9; n++) begin
      step(1);
      checks++; if ({cpu_hold, pt_grant} !== {1'b1, (n >= 9)}) begin failures++; $display("[TB] FAIL rs_edge[%0d]: got %b expected %b", n, {cpu_hold, pt_grant}, {1'b1, (n >= 9)}); end
      if (n == 6) pt_req = 1'b1;
    end
  endtask

  task automatic test_desel_reassert();
    pt_req = 1'b0;
    step(3);
    checks++; if (pt_grant !== 1'b0) begin failures++; $display("[TB] FAIL ds_entry: got %b expected 0", pt_grant); end
    pt_req = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      step(1);
      checks++; if ({cpu_hold, pt_grant} !== {1'b1, (n >= 5)}) begin failures++; $display("[TB] FAIL ds_edge[%0d]: got %b expected %b", n, {cpu_hold, pt_grant}, {1'b1, (n >= 5)}); end
    end
  endtask

  task automatic test_reset_mid_pass();
    core_csb = 1'b0;
    core_sck = 1'b1;
    #3;
    resetn = 1'b0;
    #1;
    checks++; if ({cpu_hold, pt_grant} !== 2'b00) begin failures++; $display("[TB] FAIL rst_mid_ctrl: got %b expected 00", {cpu_hold, pt_grant}); end
    checks++; if ({flash_csb, flash_clk} !== 2'b01) begin failures++; $display("[TB] FAIL rst_mid_pins: got %b expected 01", {flash_csb, flash_clk}); end
    pt_req = 1'b0;
    step(1);
    resetn = 1'b1;
    step(3);
    checks++; if ({cpu_hold, pt_grant} !== 2'b00) begin failures++; $display("[TB] FAIL rst_after: got %b expected 00", {cpu_hold, pt_grant}); end
  endtask

  // Scenario sequence; each task leaves the DUT in the state the next one
  // starts from.
  initial begin
    test_reset();
    test_idle();
    test_core_in_flight();
    test_pass_read();
    test_release();
    test_restart_reassert();
    test_desel_reassert();
    test_reset_mid_pass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
